// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl -- MIPS-style coprocessor-0 exception and timer controller.
//
// Holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config. It
// commits exceptions and eret, raises a sticky Count/Compare timer
// interrupt, and forms the pipeline interrupt request.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   we_i/waddr_i/data_i   mtc0 write strobe, register number, write data
//   raddr_i, data_o       mfc0 register number, registered read data (1 cycle)
//   hw_int_i              level-sensitive external interrupt lines
//   exc_*                 exception commit strobe, ExcCode, PC, delay-slot flag,
//                         faulting address
//   eret_i                exception return strobe
//   timer_int_o           sticky timer interrupt
//   int_req_o             combinational interrupt request to the pipeline
//   count_o..badvaddr_o   current register contents
module cp0_exc_ctrl #(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] PRID_VAL   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           data_i,
    input  logic [4:0]            raddr_i,
    output logic [31:0]           data_o,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_in_delay_i,
    input  logic [31:0]           exc_badvaddr_i,
    input  logic                  eret_i,
    output logic                  timer_int_o,
    output logic                  int_req_o,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           badvaddr_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [31:0] STATUS_RESET = 32'h10000000;
    // Prescaler is one bit: COUNT_DIV is 1 (always at terminal value) or 2.
    localparam logic        PRESC_LAST   = (COUNT_DIV == 2);

    logic [31:0] count_reg,    count_next;
    logic [31:0] compare_reg,  compare_next;
    logic [31:0] status_reg,   status_next;
    logic [31:0] cause_reg,    cause_next;
    logic [31:0] epc_reg,      epc_next;
    logic [31:0] badvaddr_reg, badvaddr_next;
    logic [31:0] data_reg,     data_next;
    logic        timer_reg,    timer_next;
    logic        presc_reg,    presc_next;

    logic [5:0]  hw_ip;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    // External lines map onto Cause[15:10]; absent lines read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ip
            if (gi < NUM_HW_INT) begin : g_used
                assign hw_ip[gi] = hw_int_i[gi];
            end else begin : g_unused
                assign hw_ip[gi] = 1'b0;
            end
        end
    endgenerate

    function automatic logic [31:0] cp0_read(
        input logic [4:0]  addr,
        input logic [31:0] bva, cnt, cmp, st, ca, epc
    );
        case (addr)
            REG_BADVADDR: cp0_read = bva;
            REG_COUNT:    cp0_read = cnt;
            REG_COMPARE:  cp0_read = cmp;
            REG_STATUS:   cp0_read = st;
            REG_CAUSE:    cp0_read = ca;
            REG_EPC:      cp0_read = epc;
            REG_PRID:     cp0_read = PRID_VAL;
            REG_CONFIG:   cp0_read = CONFIG_VAL;
            default:      cp0_read = 32'd0;
        endcase
    endfunction

    always_comb begin
        wr_count   = we_i && (waddr_i == REG_COUNT);
        wr_compare = we_i && (waddr_i == REG_COMPARE);
        wr_status  = we_i && (waddr_i == REG_STATUS);
        wr_cause   = we_i && (waddr_i == REG_CAUSE);
        wr_epc     = we_i && (waddr_i == REG_EPC);

        // Count with prescaler; a software load restarts the period.
        count_next = count_reg;
        presc_next = presc_reg;
        if (wr_count) begin
            count_next = data_i;
            presc_next = 1'b0;
        end else if (presc_reg == PRESC_LAST) begin
            count_next = count_reg + 32'd1;
            presc_next = 1'b0;
        end else begin
            presc_next = presc_reg + 1'b1;
        end

        compare_next = wr_compare ? data_i : compare_reg;

        // Compare write acknowledges the timer and beats a same-cycle match.
        timer_next = timer_reg;
        if (wr_compare)
            timer_next = 1'b0;
        else if ((count_reg == compare_reg) && (compare_reg != 32'd0))
            timer_next = 1'b1;

        // Exception owns EXL over both mtc0 and eret.
        status_next = wr_status ? data_i : status_reg;
        if (exc_valid_i)
            status_next[1] = 1'b1;
        else if (eret_i)
            status_next[1] = 1'b0;

        cause_next          = 32'd0;
        cause_next[31]      = cause_reg[31];
        cause_next[23:22]   = wr_cause ? data_i[23:22] : cause_reg[23:22];
        cause_next[15:10]   = {hw_ip[5] | timer_reg, hw_ip[4:0]};
        cause_next[9:8]     = wr_cause ? data_i[9:8] : cause_reg[9:8];
        cause_next[6:2]     = cause_reg[6:2];
        if (exc_valid_i) begin
            cause_next[6:2] = exc_code_i;
            // Nested exceptions keep the original return context.
            if (!status_reg[1])
                cause_next[31] = exc_in_delay_i;
        end

        epc_next = epc_reg;
        if (exc_valid_i) begin
            if (!status_reg[1])
                epc_next = exc_in_delay_i ? exc_pc_i - 32'd4 : exc_pc_i;
        end else if (wr_epc) begin
            epc_next = data_i;
        end

        badvaddr_next = badvaddr_reg;
        if (exc_valid_i && ((exc_code_i == 5'd4) || (exc_code_i == 5'd5)))
            badvaddr_next = exc_badvaddr_i;

        // A write to the register being read returns its post-write value.
        if (we_i && (waddr_i == raddr_i))
            data_next = cp0_read(raddr_i, badvaddr_reg, count_next, compare_next,
                                 status_next, cause_next, epc_next);
        else
            data_next = cp0_read(raddr_i, badvaddr_reg, count_reg, compare_reg,
                                 status_reg, cause_reg, epc_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= 32'd0;
            compare_reg  <= 32'd0;
            status_reg   <= STATUS_RESET;
            cause_reg    <= 32'd0;
            epc_reg      <= 32'd0;
            badvaddr_reg <= 32'd0;
            data_reg     <= 32'd0;
            timer_reg    <= 1'b0;
            presc_reg    <= 1'b0;
        end else begin
            count_reg    <= count_next;
            compare_reg  <= compare_next;
            status_reg   <= status_next;
            cause_reg    <= cause_next;
            epc_reg      <= epc_next;
            badvaddr_reg <= badvaddr_next;
            data_reg     <= data_next;
            timer_reg    <= timer_next;
            presc_reg    <= presc_next;
        end
    end

    assign int_req_o   = status_reg[0] & ~status_reg[1] &
                         (|(status_reg[15:8] & cause_reg[15:8]));
    assign data_o      = data_reg;
    assign timer_int_o = timer_reg;
    assign count_o     = count_reg;
    assign compare_o   = compare_reg;
    assign status_o    = status_reg;
    assign cause_o     = cause_reg;
    assign epc_o       = epc_reg;
    assign badvaddr_o  = badvaddr_reg;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl. Instance dut uses COUNT_DIV=1,
// instance dut2 uses COUNT_DIV=2; both share every input. Expected mfc0
// read data is queued when the read is issued and compared one cycle later.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  hw_int_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_in_delay_i;
    logic [31:0] exc_badvaddr_i;
    logic        eret_i;

    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
    logic        timer_int_o, int_req_o;
    logic [31:0] data2, count2, compare2, status2, cause2, epc2, bva2;
    logic        timer2, intreq2;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    always #5 clk = ~clk;

    cp0_exc_ctrl #(.COUNT_DIV(1)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
        .raddr_i(raddr_i), .data_o(data_o), .hw_int_i(hw_int_i),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
        .exc_in_delay_i(exc_in_delay_i), .exc_badvaddr_i(exc_badvaddr_i),
        .eret_i(eret_i), .timer_int_o(timer_int_o), .int_req_o(int_req_o),
        .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o)
    );

    cp0_exc_ctrl #(.COUNT_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
        .raddr_i(raddr_i), .data_o(data2), .hw_int_i(hw_int_i),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
        .exc_in_delay_i(exc_in_delay_i), .exc_badvaddr_i(exc_badvaddr_i),
        .eret_i(eret_i), .timer_int_o(timer2), .int_req_o(intreq2),
        .count_o(count2), .compare_o(compare2), .status_o(status2),
        .cause_o(cause2), .epc_o(epc2), .badvaddr_o(bva2)
    );

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; raddr_i = 5'd0;
        exc_valid_i = 1'b0; exc_code_i = 5'd0; exc_pc_i = 32'd0;
        exc_in_delay_i = 1'b0; exc_badvaddr_i = 32'd0; eret_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; hw_int_i = 6'd0; idle_inputs();
        tick(); tick();
        total++; if (count_o !== 32'd0) begin bad++; $display("FAIL reset_count got=%h exp=%h", count_o, 32'd0); end
        total++; if (compare_o !== 32'd0) begin bad++; $display("FAIL reset_compare got=%h exp=%h", compare_o, 32'd0); end
        total++; if (status_o !== 32'h10000000) begin bad++; $display("FAIL reset_status got=%h exp=%h", status_o, 32'h10000000); end
        total++; if ({cause_o, epc_o, badvaddr_o, data_o} !== 128'd0) begin bad++; $display("FAIL reset_regs got=%h/%h/%h/%h exp=0", cause_o, epc_o, badvaddr_o, data_o); end
        total++; if ({timer_int_o, int_req_o} !== 2'b00) begin bad++; $display("FAIL reset_irq got=%b exp=00", {timer_int_o, int_req_o}); end
        $display("reset: status=%h count=%h", status_o, count_o);
        rst = 1'b0;
    endtask

    task automatic test_timer();
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd5; raddr_i = 5'd11;
        exp_q.push_back(32'd5);
        tick();
        e = exp_q.pop_front();
        total++; if (data_o !== e) begin bad++; $display("FAIL cmp_bypass got=%h exp=%h", data_o, e); end
        $display("mtc0 Compare=5 read=%h", data_o);
        waddr_i = 5'd9; data_i = 32'd0;
        tick();
        we_i = 1'b0; raddr_i = 5'd9;
        for (int i = 1; i <= 10; i++) begin
            exp_q.push_back(32'(i - 1));
            tick();
            e = exp_q.pop_front();
            total++; if (data_o !== e) begin bad++; $display("FAIL count_read got=%h exp=%h", data_o, e); end
            total++; if (count_o !== 32'(i)) begin bad++; $display("FAIL count_inc got=%h exp=%h", count_o, 32'(i)); end
            total++; if (timer_int_o !== (i >= 6)) begin bad++; $display("FAIL timer_set i=%0d got=%b exp=%b", i, timer_int_o, (i >= 6)); end
            $display("cycle %0d count=%0d timer=%b", i, count_o, timer_int_o);
        end
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd20;
        tick();
        total++; if (timer_int_o !== 1'b0) begin bad++; $display("FAIL timer_clear got=%b exp=0", timer_int_o); end
        total++; if (compare_o !== 32'd20) begin bad++; $display("FAIL compare20 got=%h exp=%h", compare_o, 32'd20); end
        $display("mtc0 Compare=20 timer=%b", timer_int_o);
        // Compare=0 disables the timer for the rest of the run.
        data_i = 32'd0;
        tick();
        we_i = 1'b0;
    endtask

    task automatic test_exception();
        exc_valid_i = 1'b1; exc_code_i = 5'd4; exc_pc_i = 32'h1000;
        exc_in_delay_i = 1'b1; exc_badvaddr_i = 32'h1234;
        tick();
        total++; if (epc_o !== 32'h0FFC) begin bad++; $display("FAIL exc1_epc got=%h exp=%h", epc_o, 32'h0FFC); end
        total++; if ({cause_o[31], cause_o[6:2]} !== 6'b1_00100) begin bad++; $display("FAIL exc1_cause got=%h exp=BD1 code4", cause_o); end
        total++; if (badvaddr_o !== 32'h1234) begin bad++; $display("FAIL exc1_bva got=%h exp=%h", badvaddr_o, 32'h1234); end
        total++; if (status_o[1] !== 1'b1) begin bad++; $display("FAIL exc1_exl got=%b exp=1", status_o[1]); end
        $display("exc code4 epc=%h cause=%h bva=%h", epc_o, cause_o, badvaddr_o);
        exc_code_i = 5'd8; exc_pc_i = 32'h2000; exc_in_delay_i = 1'b0; exc_badvaddr_i = 32'h5555;
        tick();
        total++; if (epc_o !== 32'h0FFC) begin bad++; $display("FAIL exc2_epc got=%h exp=%h", epc_o, 32'h0FFC); end
        total++; if ({cause_o[31], cause_o[6:2]} !== 6'b1_01000) begin bad++; $display("FAIL exc2_cause got=%h exp=BD1 code8", cause_o); end
        total++; if (badvaddr_o !== 32'h1234) begin bad++; $display("FAIL exc2_bva got=%h exp=%h", badvaddr_o, 32'h1234); end
        $display("nested exc code8 epc=%h cause=%h", epc_o, cause_o);
        idle_inputs(); eret_i = 1'b1;
        tick();
        total++; if (status_o[1] !== 1'b0) begin bad++; $display("FAIL eret_exl got=%b exp=0", status_o[1]); end
        $display("eret status=%h", status_o);
        eret_i = 1'b0;
    endtask

    task automatic test_interrupt();
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000FF01;
        tick();
        we_i = 1'b0;
        total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", int_req_o); end
        hw_int_i = 6'b000001;
        tick();
        total++; if (cause_o[10] !== 1'b1) begin bad++; $display("FAIL ip2 got=%b exp=1", cause_o[10]); end
        total++; if (int_req_o !== 1'b1) begin bad++; $display("FAIL irq_on got=%b exp=1", int_req_o); end
        $display("hw_int0 cause=%h int_req=%b", cause_o, int_req_o);
        exc_valid_i = 1'b1;
        tick();
        exc_valid_i = 1'b0;
        total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL irq_exl got=%b exp=0", int_req_o); end
        eret_i = 1'b1;
        tick();
        total++; if (int_req_o !== 1'b1) begin bad++; $display("FAIL irq_eret got=%b exp=1", int_req_o); end
        exc_valid_i = 1'b1;
        tick();
        total++; if (status_o[1] !== 1'b1) begin bad++; $display("FAIL exc_beats_eret got=%b exp=1", status_o[1]); end
        $display("exc+eret status=%h int_req=%b", status_o, int_req_o);
        exc_valid_i = 1'b0;
        tick();
        eret_i = 1'b0;
        total++; if (status_o !== 32'h0000FF01) begin bad++; $display("FAIL status_back got=%h exp=%h", status_o, 32'h0000FF01); end
    endtask

    task automatic test_cause_write();
        we_i = 1'b1; waddr_i = 5'd13; data_i = 32'hFFFFFFFF; raddr_i = 5'd13;
        exp_q.push_back(32'h00C00700);
        tick();
        we_i = 1'b0;
        e = exp_q.pop_front();
        total++; if (data_o !== e) begin bad++; $display("FAIL cause_bypass got=%h exp=%h", data_o, e); end
        total++; if (cause_o !== 32'h00C00700) begin bad++; $display("FAIL cause_mask got=%h exp=%h", cause_o, 32'h00C00700); end
        $display("mtc0 Cause=ffffffff read=%h", data_o);
    endtask

    task automatic test_readonly();
        logic [4:0]  wa[4]  = '{5'd15, 5'd3, 5'd8, 5'd16};
        logic [31:0] ex[4]  = '{32'h004C0102, 32'd0, 32'h1234, 32'h00008000};
        for (int i = 0; i < 4; i++) begin
            we_i = 1'b1; waddr_i = wa[i]; data_i = 32'hDEAD0000; raddr_i = wa[i];
            exp_q.push_back(ex[i]);
            tick();
            e = exp_q.pop_front();
            total++; if (data_o !== e) begin bad++; $display("FAIL ro_read reg=%0d got=%h exp=%h", wa[i], data_o, e); end
            $display("mtc0 reg%0d ignored read=%h", wa[i], data_o);
        end
        we_i = 1'b0;
    endtask

    task automatic test_exc_mtc0();
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000FF01;
        exc_valid_i = 1'b1; exc_code_i = 5'd5; exc_pc_i = 32'h3000;
        exc_in_delay_i = 1'b1; exc_badvaddr_i = 32'hABCD;
        tick();
        idle_inputs();
        total++; if (status_o !== 32'h0000FF03) begin bad++; $display("FAIL excmtc0_status got=%h exp=%h", status_o, 32'h0000FF03); end
        total++; if (epc_o !== 32'h2FFC) begin bad++; $display("FAIL excmtc0_epc got=%h exp=%h", epc_o, 32'h2FFC); end
        total++; if (badvaddr_o !== 32'hABCD) begin bad++; $display("FAIL ades_bva got=%h exp=%h", badvaddr_o, 32'hABCD); end
        $display("exc+mtc0 status=%h epc=%h", status_o, epc_o);
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
    endtask

    task automatic test_count_wrap();
        we_i = 1'b1; waddr_i = 5'd9; data_i = 32'hFFFFFFFF;
        tick();
        we_i = 1'b0;
        total++; if ({count_o, count2} !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin bad++; $display("FAIL count_load got=%h/%h exp=ffffffff", count_o, count2); end
        tick();
        total++; if (count_o !== 32'd0) begin bad++; $display("FAIL wrap_div1 got=%h exp=0", count_o); end
        total++; if (count2 !== 32'hFFFFFFFF) begin bad++; $display("FAIL hold_div2 got=%h exp=ffffffff", count2); end
        tick();
        total++; if (count2 !== 32'd0) begin bad++; $display("FAIL wrap_div2 got=%h exp=0", count2); end
        total++; if (timer_int_o !== 1'b0) begin bad++; $display("FAIL timer_cmp0 got=%b exp=0", timer_int_o); end
        tick();
        total++; if (count2 !== 32'd0) begin bad++; $display("FAIL hold2_div2 got=%h exp=0", count2); end
        tick();
        total++; if (count2 !== 32'd1) begin bad++; $display("FAIL inc_div2 got=%h exp=1", count2); end
        $display("div2 count=%h", count2);
    endtask

    task automatic test_reset_override();
        rst = 1'b1; we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd7;
        exc_valid_i = 1'b1; exc_code_i = 5'd4; exc_pc_i = 32'h4000; exc_badvaddr_i = 32'h9;
        eret_i = 1'b1;
        tick();
        idle_inputs(); rst = 1'b0;
        total++; if ({compare_o, epc_o, badvaddr_o, cause_o} !== 128'd0) begin bad++; $display("FAIL rst_override got=%h/%h/%h/%h exp=0", compare_o, epc_o, badvaddr_o, cause_o); end
        total++; if (status_o !== 32'h10000000) begin bad++; $display("FAIL rst_status got=%h exp=%h", status_o, 32'h10000000); end
        $display("reset override status=%h", status_o);
    endtask

    initial begin
        test_reset();
        test_timer();
        test_exception();
        test_interrupt();
        test_cause_write();
        test_readonly();
        test_exc_mtc0();
        test_count_wrap();
        test_reset_override();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
